writeback_queue: RTL

Buffered writer for the 32×64-bit register file write port. It accepts register writeback requests from the pipeline over a valid/ready handshake and holds them in a small in-order FIFO. It drains one entry per enabled cycle onto the register file's RegWrite/RD/WriteData port. It also reports whether RS1 and RS2 have writes still pending, and forwards the youngest pending data, so the decode stage never reads a stale register.

---
 rtl/writeback_queue.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/writeback_queue.sv
// ---------------------------------------------------------------------------
// writeback_queue
//
// Buffered writer for the register file write port. The pipeline hands
// writeback requests over a valid/ready handshake. They sit in a small
// in-order FIFO and drain one per enabled cycle onto the register file's
// RegWrite/RD/WriteData port. While an entry waits, the decode stage can ask
// whether RS1/RS2 have a write pending, and it receives the youngest pending
// data. This keeps decode from reading a stale register.
//
// Parameters
//   DEPTH   FIFO entries (power of two, >= 2)
//   DATA_W  writeback data width
//   ADDR_W  register index width
//
// Ports
//   clk                         rising-edge clock
//   reset                       asynchronous, active-low; clears all state
//   wb_valid/wb_rd/wb_data      incoming writeback request
//   wb_ready                    queue can accept this cycle
//   drain_en                    register file write port free this cycle
//   flush                       synchronous discard of every queued entry
//   RegWrite/RD/WriteData       register file write port (from head entry)
//   RS1/RS2                     decode-stage read indices
//   rs1_pending/rs2_pending     an occupied entry targets RS1/RS2
//   rs1_fwd_data/rs2_fwd_data   youngest matching data, 0 when not pending
// ---------------------------------------------------------------------------
module writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_ready,
    input  logic              drain_en,
    input  logic              flush,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] RD,
    output logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] RS1,
    input  logic [ADDR_W-1:0] RS2,
    output logic              rs1_pending,
    output logic              rs2_pending,
    output logic [DATA_W-1:0] rs1_fwd_data,
    output logic [DATA_W-1:0] rs2_fwd_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] rd_mem   [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic push;
    logic pop;

    // wb_ready ignores a same-cycle pop. This keeps drain_en out of the
    // combinational path to the producer. A full queue therefore takes one
    // extra cycle to reopen.
    always_comb begin
        wb_ready = (count < FULL_COUNT) && !flush;
    end

    // A request to x0 completes its handshake but is dropped here. It never
    // occupies a slot, so it can neither drain nor show up as pending.
    always_comb begin
        push = wb_valid && wb_ready && (wb_rd != '0);
        pop  = (count != '0) && drain_en && !flush;
    end

    // The write port is driven straight from the head entry. The register
    // file samples it on the same edge that pops the head. Flush suppresses
    // the strobe so a discarded entry never commits.
    always_comb begin
        RegWrite  = pop;
        RD        = '0;
        WriteData = '0;
        if (pop) begin
            RD        = rd_mem[head];
            WriteData = data_mem[head];
        end
    end

    // Payload storage needs no reset. Only occupied slots are ever observed,
    // and occupancy is governed by count.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[tail]   <= wb_rd;
            data_mem[tail] <= wb_data;
        end
    end

    // Pointer and occupancy bookkeeping. Flush empties the queue outright and
    // overrides any push or pop in the same cycle. A simultaneous push and pop
    // advances both pointers and leaves count unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Hazard lookup over occupied slots only. The walk goes from oldest
    // (head) to youngest. A later match overwrites an earlier one, so the
    // result is the youngest pending write to that register. The head still
    // counts while it drains, because the register file only holds the value
    // after that edge.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx          = '0;
        rs1_pending  = 1'b0;
        rs2_pending  = 1'b0;
        rs1_fwd_data = '0;
        rs2_fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (CNT_W'(i) < count) begin
                if ((RS1 != '0) && (rd_mem[idx] == RS1)) begin
                    rs1_pending  = 1'b1;
                    rs1_fwd_data = data_mem[idx];
                end
                if ((RS2 != '0) && (rd_mem[idx] == RS2)) begin
                    rs2_pending  = 1'b1;
                    rs2_fwd_data = data_mem[idx];
                end
            end
        end
    end

endmodule
